// File: rtl/dct2d_stream.sv
`default_nettype none
// ============================================================================
// Module   : dct2d_stream
// Purpose  : 8x8 two-dimensional forward binDCT engine. One pixel block is
//            accepted per valid/ready handshake. The row pass and the column
//            pass run on the same bank of eight 1-D lifting kernels in
//            consecutive cycles. The final coefficients are shifted,
//            range-limited and held on a valid/ready output port.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            in_valid   - in_blk carries a block
//            in_ready   - block accepted when in_valid && in_ready
//            in_blk     - pixels [row][col], IN_W bits unsigned
//            out_valid  - out_coef carries a result
//            out_ready  - consumer takes the result when out_valid && out_ready
//            out_coef   - coefficients [u][v], OUT_W bits signed
//            busy       - engine is not idle
// Macro    : DCT_SAT_EN - when defined, out-of-range coefficients saturate;
//                         otherwise they wrap to the low OUT_W bits.
// Revision : 1.0 - initial release
// ============================================================================
module dct2d_stream #(
  parameter int IN_W        = 8,
  parameter int INT_W       = 18,
  parameter int OUT_W       = 14,
  parameter int OUT_SHIFT   = 2,
  parameter int LEVEL_SHIFT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0][7:0][IN_W-1:0]  in_blk,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0][7:0][OUT_W-1:0] out_coef,
  output logic                       busy
);

  typedef logic signed [INT_W-1:0] word_t;
  typedef word_t [7:0]             vec_t;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_row  = 2'd1;
  localparam logic [1:0] c_st_col  = 2'd2;
  localparam logic [1:0] c_st_out  = 2'd3;

  localparam word_t c_level_ofs = (LEVEL_SHIFT != 0) ?
                                  word_t'(longint'(1) <<< (IN_W-1)) : word_t'(0);

`ifdef DCT_SAT_EN
  localparam word_t c_sat_max = word_t'((longint'(1) <<< (OUT_W-1)) - 1);
  localparam word_t c_sat_min = word_t'(-(longint'(1) <<< (OUT_W-1)));
`endif

  // 1-D forward binDCT lifting kernel; every step wraps at INT_W.
  function automatic vec_t kernel_1d(input vec_t x);
    word_t a0, a1, a2, a3, d0, d1, d2, d3;
    word_t p, q, s, t, e, f;
    word_t m0, m1, m2, m3;
    word_t y0, y1, y2, y3, y4, y5, y6, y7;
    vec_t  y;
    a0 = x[0] + x[7];
    a1 = x[1] + x[6];
    a2 = x[2] + x[5];
    a3 = x[3] + x[4];
    d0 = x[0] - x[7];
    d1 = x[1] - x[6];
    d2 = x[2] - x[5];
    d3 = x[3] - x[4];
    // odd part
    p  = (d2 >>> 2) + (d2 >>> 3) + d1;
    q  = (p >>> 1) + (p >>> 3) - d2;
    s  = d3 + q;
    t  = d3 - q;
    e  = d0 - p;
    f  = d0 + p;
    // even part
    m0 = a0 + a3;
    m1 = a1 + a2;
    m2 = a1 - a2;
    m3 = a0 - a3;
    y0 = m0 + m1;
    y4 = (y0 >>> 1) - m1;
    y6 = m2 - (m3 >>> 2) - (m3 >>> 3);
    y2 = m3 + (y6 >>> 2) + (y6 >>> 3);
    // odd outputs
    y1 = f;
    y7 = s - (f >>> 3);
    y5 = t + e - (e >>> 3);
    y3 = e - (y5 >>> 1);
    y[0] = y0; y[1] = y1; y[2] = y2; y[3] = y3;
    y[4] = y4; y[5] = y5; y[6] = y6; y[7] = y7;
    return y;
  endfunction

  // Final scaling and range reduction of one coefficient.
  function automatic logic [OUT_W-1:0] limit(input word_t v);
    word_t sh;
    sh = v >>> OUT_SHIFT;
`ifdef DCT_SAT_EN
    if (sh > c_sat_max) begin
      sh = c_sat_max;
    end else if (sh < c_sat_min) begin
      sh = c_sat_min;
    end
`endif
    return sh[OUT_W-1:0];
  endfunction

  logic [1:0]                 state_q, state_d;
  word_t                      work_q [8][8];
  word_t                      work_d [8][8];
  logic [7:0][7:0][OUT_W-1:0] out_coef_q, out_coef_d;
  logic                       out_valid_q, out_valid_d;
  logic                       accept;
  vec_t                       kern_y [8];

  // Shared kernel bank: kernel j always works on row j of the work register.
  // Both passes write result i of kernel j to work[i][j], so each pass leaves
  // its output transposed; after the column pass that transpose restores
  // the [u][v] orientation.
  for (genvar j = 0; j < 8; j++) begin : g_kern
    vec_t row;
    always_comb begin
      for (int c = 0; c < 8; c++) begin
        row[c] = work_q[j][c];
      end
    end
    assign kern_y[j] = kernel_1d(row);
  end

  // ---------------------------------------------------------------- FSM ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = c_st_idle;
    case (state_q)
      c_st_idle: state_d = accept ? c_st_row : c_st_idle;
      c_st_row:  state_d = c_st_col;
      c_st_col:  state_d = c_st_out;
      c_st_out: begin
        if (!out_ready) begin
          state_d = c_st_out;
        end else begin
          state_d = accept ? c_st_row : c_st_idle;
        end
      end
      default:   state_d = c_st_idle;
    endcase
  end

  // In OUT a new block may enter on the same edge the result leaves,
  // which keeps the engine at one block per three cycles.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      c_st_idle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      c_st_out:  in_ready = out_ready;
      default:   in_ready = 1'b0;
    endcase
    accept = in_valid && in_ready;
  end

  // ----------------------------------------------------------- datapath ---
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        work_d[r][c] = work_q[r][c];
      end
    end
    out_coef_d  = out_coef_q;
    out_valid_d = out_valid_q;

    if (accept) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          work_d[r][c] = word_t'({{(INT_W-IN_W){1'b0}}, in_blk[r][c]}) - c_level_ofs;
        end
      end
    end

    case (state_q)
      c_st_row: begin
        for (int i = 0; i < 8; i++) begin
          for (int j = 0; j < 8; j++) begin
            work_d[i][j] = kern_y[j][i];
          end
        end
      end
      c_st_col: begin
        for (int i = 0; i < 8; i++) begin
          for (int j = 0; j < 8; j++) begin
            out_coef_d[i][j] = limit(kern_y[j][i]);
          end
        end
        out_valid_d = 1'b1;
      end
      c_st_out: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_coef_q  <= '0;
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          work_q[r][c] <= '0;
        end
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_coef_q  <= out_coef_d;
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          work_q[r][c] <= work_d[r][c];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_coef  = out_coef_q;

endmodule
`default_nettype wire

// File: tb/tb_dct2d_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_dct2d_stream
// Purpose  : Self-checking bench for dct2d_stream. Three instances share the
//            input stimulus: default parameters, raw (no level shift, no
//            output shift) and level-shift-free with OUT_SHIFT=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dct2d_stream;

  localparam int IN_W  = 8;
  localparam int OUT_W = 14;

  typedef logic [7:0][7:0][IN_W-1:0]  blk_t;
  typedef logic [7:0][7:0][OUT_W-1:0] cf_t;
  typedef logic signed [31:0]         w_t;
  typedef w_t [7:0]                   vec_t;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic in_valid  = 1'b0;
  logic out_ready = 1'b0;
  blk_t in_blk    = '0;

  logic in_ready0, in_ready1, in_ready2;
  logic out_valid0, out_valid1, out_valid2;
  logic busy0, busy1, busy2;
  cf_t  coef0, coef1, coef2;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_c [8][8];

  always #5 clk = ~clk;

  dct2d_stream u_dut_def (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_blk(in_blk), .out_valid(out_valid0), .out_ready(out_ready),
    .out_coef(coef0), .busy(busy0)
  );

  dct2d_stream #(.LEVEL_SHIFT(0), .OUT_SHIFT(0)) u_dut_raw (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_blk(in_blk), .out_valid(out_valid1), .out_ready(out_ready),
    .out_coef(coef1), .busy(busy1)
  );

  dct2d_stream #(.LEVEL_SHIFT(0), .OUT_SHIFT(2)) u_dut_sh2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_blk(in_blk), .out_valid(out_valid2), .out_ready(out_ready),
    .out_coef(coef2), .busy(busy2)
  );

  task automatic check(input string tag, input longint got, input longint want);
    n_checks++;
    if (got == want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint cf(input cf_t c, input int u, input int v);
    return longint'($signed(c[u][v]));
  endfunction

  // Reference 1-D kernel written directly from the algorithm in 32-bit ints.
  function automatic vec_t k1d(input vec_t v);
    int x [8];
    int a [4];
    int d [4];
    int p, q, s, t, e, f, m0, m1, m2, m3, y0, y2, y4, y5, y6;
    vec_t y;
    for (int i = 0; i < 8; i++) x[i] = $signed(v[i]);
    for (int k = 0; k < 4; k++) begin
      a[k] = x[k] + x[7-k];
      d[k] = x[k] - x[7-k];
    end
    p  = (d[2] >>> 2) + (d[2] >>> 3) + d[1];
    q  = (p >>> 1) + (p >>> 3) - d[2];
    s  = d[3] + q;
    t  = d[3] - q;
    e  = d[0] - p;
    f  = d[0] + p;
    m0 = a[0] + a[3];
    m1 = a[1] + a[2];
    m2 = a[1] - a[2];
    m3 = a[0] - a[3];
    y0 = m0 + m1;
    y4 = (y0 >>> 1) - m1;
    y6 = m2 - (m3 >>> 2) - (m3 >>> 3);
    y2 = m3 + (y6 >>> 2) + (y6 >>> 3);
    y5 = t + e - (e >>> 3);
    y[0] = y0;
    y[1] = f;
    y[2] = y2;
    y[3] = e - (y5 >>> 1);
    y[4] = y4;
    y[5] = y5;
    y[6] = y6;
    y[7] = s - (f >>> 3);
    return y;
  endfunction

  // Full 2-D reference: rows first, then columns, then scale and limit.
  task automatic model_2d(input blk_t b, input int ls, input int sh);
    vec_t r;
    vec_t c;
    int   tmp [8][8];
    int   val;
    for (int row = 0; row < 8; row++) begin
      for (int col = 0; col < 8; col++) r[col] = int'(b[row][col]) - ((ls != 0) ? 128 : 0);
      r = k1d(r);
      for (int v = 0; v < 8; v++) tmp[row][v] = $signed(r[v]);
    end
    for (int v = 0; v < 8; v++) begin
      for (int row = 0; row < 8; row++) c[row] = tmp[row][v];
      c = k1d(c);
      for (int u = 0; u < 8; u++) begin
        val = $signed(c[u]) >>> sh;
`ifdef DCT_SAT_EN
        if (val > 8191) val = 8191;
        else if (val < -8192) val = -8192;
`else
        val = val & 32'h3FFF;
        if (val >= 8192) val = val - 16384;
`endif
        exp_c[u][v] = val;
      end
    end
  endtask

  task automatic check_model(input cf_t c, input string tag);
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++)
        check($sformatf("%s[%0d][%0d]", tag, u, v), cf(c, u, v), exp_c[u][v]);
  endtask

  task automatic check_const(input cf_t c, input string tag, input longint dc);
    check({tag, "_dc"}, cf(c, 0, 0), dc);
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++)
        if (u != 0 || v != 0)
          check($sformatf("%s_ac[%0d][%0d]", tag, u, v), cf(c, u, v), 0);
  endtask

  function automatic blk_t rand_blk();
    blk_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[r][c] = 8'($urandom_range(0, 255));
    return b;
  endfunction

  function automatic blk_t flat_blk(input logic [7:0] p);
    blk_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[r][c] = p;
    return b;
  endfunction

  // Present a block with out_ready low, check the 2-cycle latency and that
  // in_valid with a different block is ignored while the engine works.
  task automatic send_block(input blk_t b);
    int guard;
    guard    = 0;
    in_blk   = b;
    in_valid = 1'b1;
    while (!in_ready0 && guard < 20) begin
      tick();
      guard++;
    end
    check("accept_wait", longint'(guard < 20), 1);
    tick();
    in_blk = ~b;
    check("row_valid_low", out_valid0, 0);
    check("row_in_ready", in_ready0, 0);
    tick();
    check("col_valid_low", out_valid0, 0);
    check("col_in_ready", in_ready0, 0);
    tick();
    check("lat_valid", out_valid0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drain_valid", out_valid0, 0);
    check("drain_busy", busy0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t b;
    blk_t nb;
    blk_t blks [20];
    cf_t  snap;
    int   sent, got, cyc, last;
    bit   acc;

    // ---------------------------------------------------------- reset ---
    tick(); tick(); tick();
    check("rst_valid", out_valid0, 0);
    check("rst_busy", busy0, 0);
    check("rst_busy_raw", busy1, 0);
    check("rst_busy_sh2", busy2, 0);
    check("rst_coef_zero", longint'(coef0 == '0), 1);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready0, 1);
    check("rst_in_ready_raw", in_ready1, 1);
    check("rst_in_ready_sh2", in_ready2, 1);

    // ---------------------------------------------------- flat 128 ---
    send_block(flat_blk(8'd128));
    check("raw_valid", out_valid1, 1);
    check_const(coef0, "flat128_def", 0);
`ifdef DCT_SAT_EN
    check_const(coef1, "flat128_raw", 8191);
`else
    check_const(coef1, "flat128_raw", -8192);
`endif
    check_const(coef2, "flat128_sh2", 2048);
    drain();

    // ---------------------------------------------------- flat 255 ---
    send_block(flat_blk(8'd255));
    check_const(coef2, "flat255_sh2", 4080);
    check_const(coef0, "flat255_def", 2032);
    drain();

    // ------------------------------------------------------ impulse ---
    b = '0;
    b[0][0] = 8'd255;
    send_block(b);
    check("imp_00", cf(coef2, 0, 0), 63);
    check("imp_01", cf(coef2, 0, 1), 63);
    check("imp_10", cf(coef2, 1, 0), 63);
    check("imp_22", cf(coef2, 2, 2), 46);
    check("imp_77", cf(coef2, 7, 7), 1);
    model_2d(b, 1, 2);
    check_model(coef0, "imp_def");
    drain();

    // ------------------------------------------------------- random ---
    for (int n = 0; n < 3; n++) begin
      b = rand_blk();
      send_block(b);
      model_2d(b, 1, 2);
      check_model(coef0, $sformatf("rnd%0d", n));
      drain();
    end

    // ------------------------------------------------- backpressure ---
    b  = rand_blk();
    nb = rand_blk();
    send_block(b);
    model_2d(b, 1, 2);
    check_model(coef0, "bp_first");
    snap     = coef0;
    in_blk   = nb;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("bp_in_ready", in_ready0, 0);
      check("bp_hold_valid", out_valid0, 1);
      check("bp_coef_stable", longint'(coef0 == snap), 1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_pulse_ready", in_ready0, 1);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_next_row", out_valid0, 0);
    check("bp_next_busy", busy0, 1);
    tick();
    check("bp_next_col", out_valid0, 0);
    tick();
    check("bp_next_valid", out_valid0, 1);
    model_2d(nb, 1, 2);
    check_model(coef0, "bp_next");
    drain();

    // ------------------------------------------------------- stream ---
    for (int n = 0; n < 20; n++) blks[n] = rand_blk();
    sent      = 0;
    got       = 0;
    cyc       = 0;
    last      = 0;
    out_ready = 1'b1;
    in_blk    = blks[0];
    in_valid  = 1'b1;
    while (got < 20 && cyc < 200) begin
      if (out_valid0) begin
        model_2d(blks[got], 1, 2);
        check_model(coef0, $sformatf("strm%0d", got));
        if (got > 0) check("stream_gap", cyc - last, 3);
        last = cyc;
        got++;
      end
      acc = in_valid && in_ready0;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 20) in_blk = blks[sent];
        else in_valid = 1'b0;
      end
    end
    check("stream_count", got, 20);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tick();
    check("stream_idle", busy0, 0);

    // ------------------------------------------------ reset in COL ---
    b        = rand_blk();
    in_blk   = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("col_busy", busy0, 1);
    check("col_valid", out_valid0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid0, 0);
    check("mid_rst_coef", longint'(coef0 == '0), 1);
    check("mid_rst_busy", busy0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", out_valid0, 0);
    b = rand_blk();
    send_block(b);
    model_2d(b, 1, 2);
    check_model(coef0, "post_rst");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dct2d_stream.md
# dct2d_stream

Parametrised 8x8 two-dimensional forward binDCT engine for the EPU image pipeline, the next generation of the fixed-width DCT block. It accepts one 8x8 pixel block per valid/ready handshake and runs the row and column passes on one shared 1-D lifting kernel. It returns 64 scaled, range-limited coefficients through a valid/ready output port, so it can sit directly between the block-fetch DMA buffer and the quantiser with back-to-back blocks and downstream backpressure.

## Interface
- IN_W, 8: unsigned pixel width.
- INT_W, 18: internal signed datapath width for both passes; must be at least IN_W+9.
- OUT_W, 14: signed output coefficient width.
- OUT_SHIFT, 2: arithmetic right shift applied to final coefficients, range 0..7.
- LEVEL_SHIFT, 1: when 1, subtract 2^(IN_W-1) from every pixel at input.

- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: in_blk holds a valid block.
- in_ready, output, 1: block accepted on an edge where in_valid && in_ready.
- in_blk[7:0][7:0], input, IN_W each: pixels, [row][col].
- out_valid, output, 1: out_coef holds a valid result.
- out_ready, input, 1: the consumer takes the result on an edge where out_valid && out_ready.
- out_coef[7:0][7:0], output, OUT_W each: coefficients, [u][v]; u is vertical frequency, v is horizontal frequency.
- busy, output, 1: high in any state other than IDLE.

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1. On input handshake, latch in_blk (zero-extended, then level-shifted if LEVEL_SHIFT) into the work register; go to ROW.
  - ROW: apply the 1-D kernel to each of the 8 rows. Store the result transposed in the work register. Go to COL.
  - COL: apply the kernel to each row of the transposed data, which are the original columns. Transpose back, then shift and limit into the output register. Set out_valid=1. Go to OUT.
  - OUT: hold out_coef and out_valid stable until out_ready.
    - out_ready && !in_valid: go to IDLE and clear out_valid.
    - out_ready && in_valid: accept the new block in the same edge and go to ROW. in_ready = out_ready in OUT, a combinational path.
- 1-D kernel on x0..x7, all operations at INT_W with arithmetic shifts:
  - a_k = x_k + x_(7-k) and d_k = x_k - x_(7-k), for k=0..3.
  - Odd-part lifts:
    - p = d2/4 + d2/8 + d1
    - q = p/2 + p/8 - d2
    - s = d3 + q and t = d3 - q
    - e = d0 - p and f = d0 + p
  - Even part:
    - m0 = a0+a3, m1 = a1+a2, m2 = a1-a2, m3 = a0-a3
    - y0 = m0+m1
    - y4 = y0/2 - m1
    - y6 = m2 - m3/4 - m3/8
    - y2 = m3 + y6/4 + y6/8
  - Odd outputs:
    - y1 = f
    - y7 = s - f/8
    - y5 = t + e - e/8
    - y3 = e - y5/2
- Output stage: coefficient = value >>> OUT_SHIFT, then reduced to OUT_W bits (see Configuration).
- Intermediate values wrap silently at INT_W; at the default INT_W no wrap is possible.
- Unused states go to IDLE.

## Timing
- Reset values:
  - state IDLE, out_valid 0, out_coef all 0, busy 0.
  - in_ready is 1 once rst_n is released.
  - Work register is all 0.
- Latency: accept edge T; out_valid rises after edge T+2.
- Throughput: one block per 3 cycles when out_ready is held high.
- in_valid while busy and not in OUT is ignored; in_ready=0 there.
- out_coef changes only on the edge leaving COL; it is otherwise stable, including under backpressure.
- rst_n asserted mid-block, in ROW, COL or OUT: the block is discarded immediately and all outputs go to their reset values. No partial result is ever presented.

## Configuration
- DCT_SAT_EN defined: any coefficient outside the signed OUT_W range is clamped to +(2^(OUT_W-1)-1) or -2^(OUT_W-1).
- DCT_SAT_EN undefined: the low OUT_W bits are kept (two's-complement wrap).
- In both cases the result is registered in the same cycle.

## Test plan
- Defaults, no DCT_SAT_EN: all pixels 128, LEVEL_SHIFT=1 -> out_valid 2 cycles after accept, all 64 coefficients 0.
- LEVEL_SHIFT=0, OUT_SHIFT=0, OUT_W=14, all pixels 128:
  - with DCT_SAT_EN -> DC 8191, all AC 0.
  - without DCT_SAT_EN -> DC -8192.
- LEVEL_SHIFT=0, OUT_SHIFT=2, all pixels 255 -> DC 4080, all AC 0.
- Random blocks checked against a bit-exact software model of the kernel. Hold out_ready=0 for 10 cycles:
  - out_coef is stable and in_ready=0 throughout.
  - Then pulse out_ready with in_valid=1 -> the next block is accepted on the same edge and its result appears 2 cycles later.
- Stream 20 blocks with out_ready=1 -> one result every 3 cycles, in order, no drops.
- Drop rst_n while in COL -> out_valid=0 and out_coef=0 immediately. After release, a new block completes normally.
